pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 93 +++++++++
 rtl/pipe_ctrl_if.sv | 40 ++++
 rtl/pipe_ctrl_inst_decode.sv | 115 +++++++++++
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared encodings, opcodes and control bundle for pipe_ctrl
package pipe_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I   = 3'd0,
        IMM_S   = 3'd1,
        IMM_B   = 3'd2,
        IMM_U   = 3'd3,
        IMM_J   = 3'd4,
        IMM_CSR = 3'd5
    } imm_sel_e;

    typedef enum logic [1:0] {
        A_RS1 = 2'd0,
        A_PC  = 2'd1
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2 = 2'd0,
        B_IMM = 2'd1
    } b_sel_e;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_SLT    = 4'd3,
        ALU_SLTU   = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_PASS_B = 4'd10
    } alu_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    localparam logic FWD_REG = 1'b0;
    localparam logic FWD_W   = 1'b1;

    // Fetch slots discarded after a redirect on top of the D-stage bubble (BRAM read latency)
    localparam logic [1:0] KILL_SLOTS = 2'd1;

    // Fields carried from D into X; a zero bundle is a NOP bubble
    typedef struct packed {
        a_sel_e   a_sel;
        b_sel_e   b_sel;
        alu_sel_e alu_sel;
        logic     br_un;
        logic     is_branch;
        logic     is_jump;
        logic     br_neg;
        logic     br_cmp_lt;
        logic     mem_wen;
        logic     csr_wen;
        logic     csr_sel;
        wb_sel_e  wb_sel;
        logic     reg_wen;
    } ctrl_t;

    // funct3/funct7[5] to ALU operation for OP and OP-IMM
    function automatic alu_sel_e alu_decode(input logic [2:0] f3, input logic alt);
        alu_sel_e res;
        case (f3)
            3'b000:  res = alt ? ALU_SUB : ALU_ADD;
            3'b001:  res = ALU_SLL;
            3'b010:  res = ALU_SLT;
            3'b011:  res = ALU_SLTU;
            3'b100:  res = ALU_XOR;
            3'b101:  res = alt ? ALU_SRA : ALU_SRL;
            3'b110:  res = ALU_OR;
            default: res = ALU_AND;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - datapath-facing control bus of pipe_ctrl
interface pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      inst_d;
    logic             br_eq;
    logic             br_lt;
    logic [2:0]       imm_sel_d;
    logic [1:0]       a_sel_x;
    logic [1:0]       b_sel_x;
    logic [3:0]       alu_sel_x;
    logic             br_un_x;
    logic             mem_wen_x;
    logic             csr_wen_x;
    logic             csr_sel_x;
    logic             fwd_a_x;
    logic             fwd_b_x;
    logic [1:0]       wb_sel_w;
    logic             reg_wen_w;
    logic             pc_sel;
    logic             stall;
    logic             valid_x;
    logic             valid_w;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;

    modport master (
        output inst_d, br_eq, br_lt,
        input  imm_sel_d, a_sel_x, b_sel_x, alu_sel_x, br_un_x, mem_wen_x, csr_wen_x,
               csr_sel_x, fwd_a_x, fwd_b_x, wb_sel_w, reg_wen_w, pc_sel, stall,
               valid_x, valid_w, cycle_cnt, instret_cnt
    );

    modport slave (
        input  inst_d, br_eq, br_lt,
        output imm_sel_d, a_sel_x, b_sel_x, alu_sel_x, br_un_x, mem_wen_x, csr_wen_x,
               csr_sel_x, fwd_a_x, fwd_b_x, wb_sel_w, reg_wen_w, pc_sel, stall,
               valid_x, valid_w, cycle_cnt, instret_cnt
    );
endinterface

// File: rtl/pipe_ctrl_inst_decode.sv
// rtl/pipe_ctrl_inst_decode.sv - combinational RV32I instruction to control bundle decoder
module inst_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output imm_sel_e    imm_sel,
    output ctrl_t       ctrl,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        rs1_used,
    output logic        rs2_used,
    output logic        valid
);
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign funct3      = inst[14:12];
    assign rd          = inst[11:7];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign unused_bits = ^{inst[31], inst[29:25]};

    // Decode opcode/funct fields; unknown encodings fall back to an all-zero bubble
    always_comb begin
        imm_sel  = IMM_I;
        ctrl     = '0;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        valid    = 1'b1;
        case (opcode)
            OPC_LUI: begin
                imm_sel      = IMM_U;
                ctrl.b_sel   = B_IMM;
                ctrl.alu_sel = ALU_PASS_B;
                ctrl.reg_wen = 1'b1;
            end
            OPC_AUIPC: begin
                imm_sel      = IMM_U;
                ctrl.a_sel   = A_PC;
                ctrl.b_sel   = B_IMM;
                ctrl.reg_wen = 1'b1;
            end
            OPC_JAL: begin
                imm_sel      = IMM_J;
                ctrl.a_sel   = A_PC;
                ctrl.b_sel   = B_IMM;
                ctrl.is_jump = 1'b1;
                ctrl.wb_sel  = WB_PC4;
                ctrl.reg_wen = 1'b1;
            end
            OPC_JALR: begin
                ctrl.b_sel   = B_IMM;
                ctrl.is_jump = 1'b1;
                ctrl.wb_sel  = WB_PC4;
                ctrl.reg_wen = 1'b1;
                rs1_used     = 1'b1;
            end
            OPC_BRANCH: begin
                imm_sel        = IMM_B;
                ctrl.a_sel     = A_PC;
                ctrl.b_sel     = B_IMM;
                ctrl.is_branch = 1'b1;
                ctrl.br_un     = funct3[1];
                ctrl.br_neg    = funct3[0];
                ctrl.br_cmp_lt = funct3[2];
                rs1_used       = 1'b1;
                rs2_used       = 1'b1;
                valid          = (funct3[2:1] != 2'b01);
            end
            OPC_LOAD: begin
                ctrl.b_sel   = B_IMM;
                ctrl.wb_sel  = WB_MEM;
                ctrl.reg_wen = 1'b1;
                rs1_used     = 1'b1;
            end
            OPC_STORE: begin
                imm_sel      = IMM_S;
                ctrl.b_sel   = B_IMM;
                ctrl.mem_wen = 1'b1;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.b_sel   = B_IMM;
                ctrl.alu_sel = alu_decode(funct3, inst[30] && (funct3 == 3'b101));
                ctrl.reg_wen = 1'b1;
                rs1_used     = 1'b1;
            end
            OPC_OP: begin
                ctrl.alu_sel = alu_decode(funct3, inst[30]);
                ctrl.reg_wen = 1'b1;
                rs1_used     = 1'b1;
                rs2_used     = 1'b1;
            end
            OPC_SYSTEM: begin
                // Only CSRRW (rs1 source) and CSRRWI (zimm source) are supported
                imm_sel      = IMM_CSR;
                ctrl.csr_wen = 1'b1;
                ctrl.csr_sel = inst[14];
                rs1_used     = !inst[14];
                valid        = (funct3[1:0] == 2'b01);
            end
            default: valid = 1'b0;
        endcase
        if (!valid) begin
            imm_sel  = IMM_I;
            ctrl     = '0;
            rs1_used = 1'b0;
            rs2_used = 1'b0;
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 3-stage D/X/W pipeline controller with forwarding/stall and redirect kill
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
)
(
    input  logic      clk,
    input  logic      rst,
    pipe_ctrl_if.slave bus
);
    imm_sel_e   dec_imm_sel;
    ctrl_t      dec_ctrl;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic       rs1_used_d, rs2_used_d, dec_valid;

    ctrl_t      ctrl_x_q, ctrl_x_d;
    logic [4:0] rs1_x_q, rs1_x_d, rs2_x_q, rs2_x_d, rd_x_q, rd_x_d;
    logic       valid_x_q, valid_x_d;

    wb_sel_e    wb_sel_w_q, wb_sel_w_d;
    logic       reg_wen_w_q, reg_wen_w_d;
    logic [4:0] rd_w_q, rd_w_d;
    logic       valid_w_q, valid_w_d;

    logic [1:0] kill_q, kill_d;

    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    logic br_taken_x, pc_sel_c, kill_active, hazard_d, stall_c, d_adv;
    logic fwd_a_c, fwd_b_c;

    inst_decode u_dec (
        .inst     (bus.inst_d),
        .imm_sel  (dec_imm_sel),
        .ctrl     (dec_ctrl),
        .rs1      (rs1_d),
        .rs2      (rs2_d),
        .rd       (rd_d),
        .rs1_used (rs1_used_d),
        .rs2_used (rs2_used_d),
        .valid    (dec_valid)
    );

    // Redirect, RAW stall and W-to-X forwarding decisions; redirect overrides stall
    always_comb begin
        br_taken_x  = ctrl_x_q.br_neg ^ (ctrl_x_q.br_cmp_lt ? bus.br_lt : bus.br_eq);
        pc_sel_c    = !rst && valid_x_q
                      && (ctrl_x_q.is_jump || (ctrl_x_q.is_branch && br_taken_x));
        kill_active = (kill_q != 2'd0);
        hazard_d    = !FWD_EN && valid_x_q && ctrl_x_q.reg_wen && (rd_x_q != 5'd0)
                      && ((rs1_used_d && (rs1_d == rd_x_q)) || (rs2_used_d && (rs2_d == rd_x_q)));
        stall_c     = !rst && hazard_d && !pc_sel_c && !kill_active;
        d_adv       = dec_valid && !kill_active && !pc_sel_c && !stall_c;
        fwd_a_c     = FWD_EN && !rst && valid_w_q && reg_wen_w_q && (rd_w_q != 5'd0)
                      && (rd_w_q == rs1_x_q);
        fwd_b_c     = FWD_EN && !rst && valid_w_q && reg_wen_w_q && (rd_w_q != 5'd0)
                      && (rd_w_q == rs2_x_q);
    end

    // Next-state: D->X (bubble when killed/stalled/unknown), X->W, kill countdown, counters
    always_comb begin
        ctrl_x_d      = '0;
        rs1_x_d       = 5'd0;
        rs2_x_d       = 5'd0;
        rd_x_d        = 5'd0;
        valid_x_d     = 1'b0;
        if (d_adv) begin
            ctrl_x_d  = dec_ctrl;
            rs1_x_d   = rs1_d;
            rs2_x_d   = rs2_d;
            rd_x_d    = rd_d;
            valid_x_d = 1'b1;
        end
        wb_sel_w_d    = valid_x_q ? ctrl_x_q.wb_sel : WB_ALU;
        reg_wen_w_d   = valid_x_q && ctrl_x_q.reg_wen;
        rd_w_d        = valid_x_q ? rd_x_q : 5'd0;
        valid_w_d     = valid_x_q;
        kill_d        = kill_q;
        if (pc_sel_c) begin
            kill_d    = KILL_SLOTS;
        end else if (kill_active) begin
            kill_d    = kill_q - 2'd1;
        end
        cycle_cnt_d   = cycle_cnt_q + CNT_W'(1);
        instret_cnt_d = instret_cnt_q + CNT_W'(valid_w_q);
    end

    // Pipeline state register with synchronous reset to an empty NOP pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_x_q      <= '0;
            rs1_x_q       <= 5'd0;
            rs2_x_q       <= 5'd0;
            rd_x_q        <= 5'd0;
            valid_x_q     <= 1'b0;
            wb_sel_w_q    <= WB_ALU;
            reg_wen_w_q   <= 1'b0;
            rd_w_q        <= 5'd0;
            valid_w_q     <= 1'b0;
            kill_q        <= 2'd0;
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            ctrl_x_q      <= ctrl_x_d;
            rs1_x_q       <= rs1_x_d;
            rs2_x_q       <= rs2_x_d;
            rd_x_q        <= rd_x_d;
            valid_x_q     <= valid_x_d;
            wb_sel_w_q    <= wb_sel_w_d;
            reg_wen_w_q   <= reg_wen_w_d;
            rd_w_q        <= rd_w_d;
            valid_w_q     <= valid_w_d;
            kill_q        <= kill_d;
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign bus.imm_sel_d   = dec_imm_sel;
    assign bus.a_sel_x     = ctrl_x_q.a_sel;
    assign bus.b_sel_x     = ctrl_x_q.b_sel;
    assign bus.alu_sel_x   = ctrl_x_q.alu_sel;
    assign bus.br_un_x     = ctrl_x_q.br_un;
    assign bus.mem_wen_x   = valid_x_q && ctrl_x_q.mem_wen;
    assign bus.csr_wen_x   = valid_x_q && ctrl_x_q.csr_wen;
    assign bus.csr_sel_x   = ctrl_x_q.csr_sel;
    assign bus.fwd_a_x     = fwd_a_c ? FWD_W : FWD_REG;
    assign bus.fwd_b_x     = fwd_b_c ? FWD_W : FWD_REG;
    assign bus.wb_sel_w    = wb_sel_w_q;
    assign bus.reg_wen_w   = valid_w_q && reg_wen_w_q;
    assign bus.pc_sel      = pc_sel_c;
    assign bus.stall       = stall_c;
    assign bus.valid_x     = valid_x_q;
    assign bus.valid_w     = valid_w_q;
    assign bus.cycle_cnt   = cycle_cnt_q;
    assign bus.instret_cnt = instret_cnt_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed table-driven bench for pipe_ctrl
module tb_pipe_ctrl;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] ADDI1  = 32'h00500093;
    localparam logic [31:0] ADD211 = 32'h00108133;
    localparam logic [31:0] BEQ    = 32'h00310863;
    localparam logic [31:0] SW     = 32'h00112223;
    localparam int NV = 17;

    typedef struct {
        logic [31:0] inst;
        logic        eq;
        logic        lt;
        logic [2:0]  imm;
        logic        vx;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [3:0]  alu;
        logic        bun;
        logic        mw;
        logic        cw;
        logic        cs;
        logic        pcs;
        logic [1:0]  wb;
        logic        rw;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t vecs [NV];

    pipe_ctrl_if #(.CNT_W(32)) if_f ();
    pipe_ctrl_if #(.CNT_W(32)) if_s ();
    pipe_ctrl_if #(.CNT_W(4))  if_c ();

    pipe_ctrl #(.FWD_EN(1'b1), .CNT_W(32)) u_fwd (.clk(clk), .rst(rst), .bus(if_f));
    pipe_ctrl #(.FWD_EN(1'b0), .CNT_W(32)) u_stl (.clk(clk), .rst(rst), .bus(if_s));
    pipe_ctrl #(.FWD_EN(1'b1), .CNT_W(4))  u_c4  (.clk(clk), .rst(rst), .bus(if_c));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_f.inst_d = NOP; if_f.br_eq = 1'b0; if_f.br_lt = 1'b0;
        if_s.inst_d = NOP; if_s.br_eq = 1'b0; if_s.br_lt = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        checks = 0;
        errors = 0;
        if_c.inst_d = NOP; if_c.br_eq = 1'b0; if_c.br_lt = 1'b0;

        //           inst          eq    lt    imm   vx    a      b      alu    bun   mw    cw    cs    pcs   wb     rw
        vecs[0]  = '{32'h00500093, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 2'd1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[1]  = '{32'h00108133, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 2'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[2]  = '{32'h40108133, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 2'd0, 4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[3]  = '{32'h123450b7, 1'b0, 1'b0, 3'd3, 1'b1, 2'd0, 2'd1, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[4]  = '{32'h00001097, 1'b0, 1'b0, 3'd3, 1'b1, 2'd1, 2'd1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[5]  = '{32'h008000ef, 1'b0, 1'b0, 3'd4, 1'b1, 2'd1, 2'd1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
        vecs[6]  = '{32'h00012083, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 2'd1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        vecs[7]  = '{32'h00112223, 1'b0, 1'b0, 3'd1, 1'b1, 2'd0, 2'd1, 4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[8]  = '{32'h02316063, 1'b0, 1'b1, 3'd2, 1'b1, 2'd1, 2'd1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[9]  = '{32'h00310863, 1'b0, 1'b0, 3'd2, 1'b1, 2'd1, 2'd1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[10] = '{32'h51e09073, 1'b0, 1'b0, 3'd5, 1'b1, 2'd0, 2'd0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[11] = '{32'h51e2d073, 1'b0, 1'b0, 3'd5, 1'b1, 2'd0, 2'd0, 4'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[12] = '{32'hffffffff, 1'b0, 1'b0, 3'd0, 1'b0, 2'd0, 2'd0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[13] = '{32'hfff0c093, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 2'd1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[14] = '{32'h4030d093, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 2'd1, 4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        vecs[15] = '{32'h02317063, 1'b0, 1'b1, 3'd2, 1'b1, 2'd1, 2'd1, 4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[16] = '{32'h000100e7, 1'b0, 1'b0, 3'd0, 1'b1, 2'd0, 2'd1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1};

        // Reset state
        do_reset();
        chk("rst valid_x",  32'(if_f.valid_x), 32'd0);
        chk("rst valid_w",  32'(if_f.valid_w), 32'd0);
        chk("rst pc_sel",   32'(if_f.pc_sel), 32'd0);
        chk("rst stall",    32'(if_s.stall), 32'd0);
        chk("rst fwd_a",    32'(if_f.fwd_a_x), 32'd0);
        chk("rst reg_wen",  32'(if_f.reg_wen_w), 32'd0);
        chk("rst cycle",    if_f.cycle_cnt, 32'd0);
        chk("rst instret",  if_f.instret_cnt, 32'd0);

        // Decode table: D-stage imm_sel, X-stage controls, W-stage writeback
        for (int i = 0; i < NV; i++) begin
            if_f.inst_d = vecs[i].inst;
            if_f.br_eq  = vecs[i].eq;
            if_f.br_lt  = vecs[i].lt;
            #1;
            chk($sformatf("v%0d imm_sel_d", i), 32'(if_f.imm_sel_d), 32'(vecs[i].imm));
            tick();
            chk($sformatf("v%0d valid_x", i),   32'(if_f.valid_x),   32'(vecs[i].vx));
            chk($sformatf("v%0d a_sel_x", i),   32'(if_f.a_sel_x),   32'(vecs[i].a));
            chk($sformatf("v%0d b_sel_x", i),   32'(if_f.b_sel_x),   32'(vecs[i].b));
            chk($sformatf("v%0d alu_sel_x", i), 32'(if_f.alu_sel_x), 32'(vecs[i].alu));
            chk($sformatf("v%0d br_un_x", i),   32'(if_f.br_un_x),   32'(vecs[i].bun));
            chk($sformatf("v%0d mem_wen_x", i), 32'(if_f.mem_wen_x), 32'(vecs[i].mw));
            chk($sformatf("v%0d csr_wen_x", i), 32'(if_f.csr_wen_x), 32'(vecs[i].cw));
            chk($sformatf("v%0d csr_sel_x", i), 32'(if_f.csr_sel_x), 32'(vecs[i].cs));
            chk($sformatf("v%0d pc_sel", i),    32'(if_f.pc_sel),    32'(vecs[i].pcs));
            if_f.inst_d = NOP;
            if_f.br_eq  = 1'b0;
            if_f.br_lt  = 1'b0;
            tick();
            chk($sformatf("v%0d valid_w", i),   32'(if_f.valid_w),   32'(vecs[i].vx));
            chk($sformatf("v%0d wb_sel_w", i),  32'(if_f.wb_sel_w),  32'(vecs[i].wb));
            chk($sformatf("v%0d reg_wen_w", i), 32'(if_f.reg_wen_w), 32'(vecs[i].rw));
            tick();
            tick();
        end

        // Forwarding: addi x1 then add x2,x1,x1
        do_reset();
        if_f.inst_d = ADDI1;
        tick();
        if_f.inst_d = ADD211;
        #1;
        chk("fwd stall d", 32'(if_f.stall), 32'd0);
        tick();
        if_f.inst_d = NOP;
        #1;
        chk("fwd valid_x", 32'(if_f.valid_x), 32'd1);
        chk("fwd fwd_a_x", 32'(if_f.fwd_a_x), 32'd1);
        chk("fwd fwd_b_x", 32'(if_f.fwd_b_x), 32'd1);
        chk("fwd stall x", 32'(if_f.stall), 32'd0);

        // Stall: same pair with forwarding disabled, D held by the bench while stalled
        do_reset();
        if_s.inst_d = ADDI1;
        tick();
        if_s.inst_d = ADD211;
        #1;
        chk("stl stall c1", 32'(if_s.stall), 32'd1);
        tick();
        chk("stl valid_x c2", 32'(if_s.valid_x), 32'd0);
        chk("stl stall c2",   32'(if_s.stall), 32'd0);
        tick();
        if_s.inst_d = NOP;
        #1;
        chk("stl valid_x c3", 32'(if_s.valid_x), 32'd1);
        chk("stl fwd_a c3",   32'(if_s.fwd_a_x), 32'd0);
        chk("stl fwd_b c3",   32'(if_s.fwd_b_x), 32'd0);
        chk("stl stall c3",   32'(if_s.stall), 32'd0);

        // Taken beq: two wrong-path sw slots become bubbles and do not retire
        do_reset();
        if_f.inst_d = BEQ;
        if_f.br_eq  = 1'b1;
        tick();
        chk("br pc_sel", 32'(if_f.pc_sel), 32'd1);
        if_f.inst_d = SW;
        tick();
        chk("br pc_sel off",  32'(if_f.pc_sel), 32'd0);
        chk("br slot1 valid", 32'(if_f.valid_x), 32'd0);
        chk("br slot1 mwen",  32'(if_f.mem_wen_x), 32'd0);
        tick();
        chk("br slot2 valid", 32'(if_f.valid_x), 32'd0);
        chk("br slot2 mwen",  32'(if_f.mem_wen_x), 32'd0);
        if_f.inst_d = NOP;
        if_f.br_eq  = 1'b0;
        tick();
        chk("br target valid", 32'(if_f.valid_x), 32'd1);
        tick();
        chk("br instret", if_f.instret_cnt, 32'd1);
        chk("br cycle",   if_f.cycle_cnt, 32'd5);

        // Counter wrap with CNT_W=4
        do_reset();
        repeat (17) tick();
        chk("c4 cycle wrap",   32'(if_c.cycle_cnt), 32'd1);
        chk("c4 instret",      32'(if_c.instret_cnt), 32'd15);

        // Reset while stalled
        do_reset();
        if_s.inst_d = ADDI1;
        tick();
        if_s.inst_d = ADD211;
        #1;
        chk("rs stall pre", 32'(if_s.stall), 32'd1);
        rst = 1'b1;
        tick();
        chk("rs valid_x", 32'(if_s.valid_x), 32'd0);
        chk("rs valid_w", 32'(if_s.valid_w), 32'd0);
        chk("rs reg_wen", 32'(if_s.reg_wen_w), 32'd0);
        chk("rs stall",   32'(if_s.stall), 32'd0);
        chk("rs alu_sel", 32'(if_s.alu_sel_x), 32'd0);
        chk("rs cycle",   if_s.cycle_cnt, 32'd0);
        chk("rs instret", if_s.instret_cnt, 32'd0);

        // Reset during a kill slot
        do_reset();
        if_f.inst_d = BEQ;
        if_f.br_eq  = 1'b1;
        tick();
        if_f.inst_d = SW;
        tick();
        rst = 1'b1;
        tick();
        chk("rk valid_x", 32'(if_f.valid_x), 32'd0);
        chk("rk valid_w", 32'(if_f.valid_w), 32'd0);
        chk("rk pc_sel",  32'(if_f.pc_sel), 32'd0);
        chk("rk mem_wen", 32'(if_f.mem_wen_x), 32'd0);
        chk("rk cycle",   if_f.cycle_cnt, 32'd0);

        // Reset while a redirect is pending must also clear the kill counter
        do_reset();
        if_f.inst_d = BEQ;
        if_f.br_eq  = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("rr pc_sel gated", 32'(if_f.pc_sel), 32'd0);
        tick();
        rst = 1'b0;
        if_f.inst_d = NOP;
        if_f.br_eq  = 1'b0;
        tick();
        chk("rr no kill valid_x", 32'(if_f.valid_x), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
